// File: rtl/axi_ram_pkg.sv
// ---------------------------------------------------------------------------
// axi_ram_pkg
// Shared definitions for the AXI burst RAM responder:
//   - read/write FSM state encodings
//   - LFSR seed and tap mask for the optional random back-pressure
//     generator (enabled with AXI_RAM_RAND_BP_EN)
//   - default RAM depth (log2, in 32-bit words)
//   - byte-lane merge helper used by the RAM write port
// ---------------------------------------------------------------------------
package axi_ram_pkg;

    localparam int DEFAULT_MEM_AW = 12;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Fibonacci taps 8,6,5,4 -> state bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        if (strb[0]) r[7:0]   = new_w[7:0];
        if (strb[1]) r[15:8]  = new_w[15:8];
        if (strb[2]) r[23:16] = new_w[23:16];
        if (strb[3]) r[31:24] = new_w[31:24];
        return r;
    endfunction

endpackage

// File: rtl/axi_ram_lfsr8.sv
// ---------------------------------------------------------------------------
// axi_ram_lfsr8
// 8-bit Fibonacci LFSR used to generate pseudo-random back-pressure.
// Only instantiated when AXI_RAM_RAND_BP_EN is defined.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (state <= seed)
//   en_i     in   advance one step this cycle
//   state_o  out  current 8-bit LFSR state
// ---------------------------------------------------------------------------
module axi_ram_lfsr8
    import axi_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/axi_burst_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_burst_ram_slave
// AXI4-subset responder: word-addressed RAM serving INCR burst reads and
// writes (cache refill, dirty writeback, uncached single beats). Read and
// write channels have independent FSMs, one outstanding burst each.
// Word index = addr[MEM_AW+1:2]; other address bits alias. Burst addresses
// wrap modulo the RAM depth.
//
// Optional feature: define AXI_RAM_RAND_BP_EN to add LFSR-driven random
// back-pressure on arready/awready/wready and random delay of rvalid.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   araddr/arlen/arvalid     read address channel (in), arready (out)
//   rdata/rlast/rvalid       read data channel (out), rready (in)
//   awaddr/awlen/awsize      write address channel (in); awsize unused
//   awvalid (in), awready (out)
//   wdata/wstrb/wlast/wvalid write data channel (in), wready (out)
//   bvalid (out), bready(in) write response channel
//   proto_err (out)          sticky wlast/awlen mismatch flag
// ---------------------------------------------------------------------------
module axi_burst_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int    ADDR_WIDTH = 32,
    parameter int    MEM_AW     = DEFAULT_MEM_AW,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  proto_err
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem_q [DEPTH];

    // bp_ok gates the ready outputs; beat_go permits rvalid to rise
    logic bp_ok;
    logic beat_go;

`ifdef AXI_RAM_RAND_BP_EN
    logic [7:0] lfsr;

    axi_ram_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign bp_ok   = lfsr[0];
    assign beat_go = lfsr[1];

    wire unused_lfsr = ^lfsr[7:2];
`else
    assign bp_ok   = 1'b1;
    assign beat_go = 1'b1;
`endif

    wire unused_addr = ^{awsize, araddr[1:0], awaddr[1:0],
                         araddr[ADDR_WIDTH-1:MEM_AW+2],
                         awaddr[ADDR_WIDTH-1:MEM_AW+2]};

    // ---------------- read channel ----------------
    logic [0:0]        rstate_q, rstate_d;
    logic [MEM_AW-1:0] rbase_q,  rbase_d;
    logic [7:0]        rlen_q,   rlen_d;
    logic [7:0]        rcnt_q,   rcnt_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q,  rdata_d;

    logic [MEM_AW-1:0] ar_idx;
    logic [MEM_AW-1:0] rnext_idx;

    assign ar_idx    = araddr[MEM_AW+1:2];
    assign rnext_idx = rbase_q + MEM_AW'(rcnt_q) + MEM_AW'(1);

    // rdata is registered when a beat is loaded, so it stays stable through
    // stalls even if the write channel updates the same word meanwhile.
    always_comb begin
        rstate_d = rstate_q;
        rbase_d  = rbase_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    rstate_d = R_DATA;
                    rbase_d  = ar_idx;
                    rlen_d   = arlen;
                    rcnt_d   = 8'd0;
                    rdata_d  = mem_q[ar_idx];
                    rvalid_d = beat_go;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = R_IDLE;
                        rvalid_d = 1'b0;
                    end else begin
                        rcnt_d   = rcnt_q + 8'd1;
                        rdata_d  = mem_q[rnext_idx];
                        rvalid_d = beat_go;
                    end
                end else if (!rvalid_q && beat_go) begin
                    rvalid_d = 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rbase_q  <= '0;
            rlen_q   <= 8'd0;
            rcnt_q   <= 8'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rstate_q <= rstate_d;
            rbase_q  <= rbase_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign arready = (rstate_q == R_IDLE) && bp_ok;
    assign rvalid  = rvalid_q;
    assign rlast   = rvalid_q && (rcnt_q == rlen_q);
    assign rdata   = rdata_q;

    // ---------------- write channel ----------------
    logic [1:0]        wstate_q, wstate_d;
    logic [MEM_AW-1:0] wbase_q,  wbase_d;
    logic [7:0]        wlen_q,   wlen_d;
    logic [7:0]        wcnt_q,   wcnt_d;
    logic              perr_q,   perr_d;

    logic [MEM_AW-1:0] w_idx;
    logic              w_hs;
    logic              mem_we;

    assign w_idx  = wbase_q + MEM_AW'(wcnt_q);
    assign w_hs   = wvalid && wready;
    // beats past awlen are accepted but dropped
    assign mem_we = w_hs && (wcnt_q <= wlen_q) && !rst;

    always_comb begin
        wstate_d = wstate_q;
        wbase_d  = wbase_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        perr_d   = perr_q;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    wstate_d = W_DATA;
                    wbase_d  = awaddr[MEM_AW+1:2];
                    wlen_d   = awlen;
                    wcnt_d   = 8'd0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if ((wlast && (wcnt_q != wlen_q)) || (wcnt_q > wlen_q)) begin
                        perr_d = 1'b1;
                    end
                    // wlast alone ends the burst, whatever awlen said
                    if (wlast) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wbase_q  <= '0;
            wlen_q   <= 8'd0;
            wcnt_q   <= 8'd0;
            perr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wbase_q  <= wbase_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[w_idx] <= byte_merge(mem_q[w_idx], wdata, wstrb);
        end
    end

    assign awready   = (wstate_q == W_IDLE) && bp_ok;
    assign wready    = (wstate_q == W_DATA) && bp_ok;
    assign bvalid    = (wstate_q == W_RESP);
    assign proto_err = perr_q;

endmodule
